// File: rtl/downlink_frame_parser.sv
// downlink_frame_parser: finds the 11011101 preamble in the decoded bit stream and commits the 8-bit camera config that follows
module downlink_frame_parser #(
  parameter logic [7:0] PREAMBLE    = 8'b11011101,
  parameter int         GAP_TIMEOUT = 20000,
  parameter int         TIMER_WIDTH = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       detected,
  input  logic       downlink_bit,
  output logic       resolution,
  output logic [2:0] compression,
  output logic [2:0] repetition,
  output logic       cfg_valid,
  output logic       frame_error,
  output logic       busy
);
  typedef enum logic {HUNT, PAYLOAD} state_t;
  localparam logic [TIMER_WIDTH-1:0] TMAX = TIMER_WIDTH'(GAP_TIMEOUT);
  state_t                 state;
  logic [7:0]             sr, p;
  logic [2:0]             cnt;
  logic [TIMER_WIDTH-1:0] timer;
  logic [7:0]             sr_n, p_n;
  logic                   hit, timeout;
  always_comb begin
    sr_n    = {sr[6:0], downlink_bit};
    p_n     = {p[6:0], downlink_bit};
    hit     = sr_n == PREAMBLE;
    timeout = timer == TMAX;
  end
  assign busy = state == PAYLOAD;
  // a consumed bit always takes priority over a timeout landing in the same cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= HUNT;
      sr          <= 8'h00;
      p           <= 8'h00;
      cnt         <= 3'd0;
      timer       <= '0;
      resolution  <= 1'b0;
      compression <= 3'b000;
      repetition  <= 3'b000;
      cfg_valid   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      cfg_valid   <= 1'b0;
      frame_error <= 1'b0;
      if (detected) begin
        timer <= '0;
        if (state == HUNT) begin
          sr    <= hit ? 8'h00 : sr_n;
          state <= hit ? PAYLOAD : HUNT;
          cnt   <= 3'd0;
        end else begin
          p   <= p_n;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state <= HUNT;
            sr    <= 8'h00;
            if (!downlink_bit) begin
              resolution  <= p_n[7];
              compression <= p_n[6:4];
              repetition  <= p_n[3:1];
              cfg_valid   <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end
        end
      end else if (timeout) begin
        sr <= 8'h00;
        if (state == PAYLOAD) begin
          state       <= HUNT;
          p           <= 8'h00;
          frame_error <= 1'b1;
        end
      end else begin
        timer <= timer + TIMER_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_downlink_frame_parser.sv
// tb_downlink_frame_parser: directed frames, garbage prefix, bad reserved bit, gap timeouts, back-to-back bits and mid-frame reset
module tb_downlink_frame_parser;
  logic       clock = 1'b0, reset = 1'b1, detected = 1'b0, downlink_bit = 1'b0;
  logic       resolution, cfg_valid, frame_error, busy;
  logic [2:0] compression, repetition;
  int checks = 0, errors = 0, cv_cnt = 0, fe_cnt = 0, both_cnt = 0;

  downlink_frame_parser dut (
    .clock(clock), .reset(reset), .detected(detected), .downlink_bit(downlink_bit),
    .resolution(resolution), .compression(compression), .repetition(repetition),
    .cfg_valid(cfg_valid), .frame_error(frame_error), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cv_cnt   <= cv_cnt + int'(cfg_valid);
    fe_cnt   <= fe_cnt + int'(frame_error);
    both_cnt <= both_cnt + int'(cfg_valid & frame_error);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // bits w[n-1:0] MSB first, gap idle cycles between bits; returns at the negedge after the last bit was sampled
  task automatic send(input logic [15:0] w, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      detected = 1'b1;
      downlink_bit = w[i];
      @(negedge clock);
      detected = 1'b0;
      if (i > 0) idle(gap);
    end
  endtask

  function automatic logic [6:0] cfg();
    return {resolution, compression, repetition};
  endfunction

  initial begin
    #1 reset = 1'b0;
    #1;
    check("rst_cfg", 32'(cfg()), 32'h0);
    check("rst_flags", {cfg_valid, frame_error, busy}, 3'b000);
    idle(2);
    reset = 1'b1;
    idle(1);
    // frame with 10-cycle gaps
    send(16'h00DD, 8, 10);
    check("t1_busy_after_preamble", busy, 1'b1);
    idle(10);
    send(16'b10110110, 8, 10);
    check("t1_cfg_valid", {cfg_valid, frame_error, busy}, 3'b100);
    check("t1_cfg", 32'(cfg()), 7'b1011011);
    idle(1);
    check("t1_cfg_valid_drop", cfg_valid, 1'b0);
    idle(2);
    check("t1_pulses", {cv_cnt[7:0], fe_cnt[7:0]}, 16'h0100);
    // garbage prefix before the preamble
    idle(5);
    send(16'b0111, 4, 3);
    idle(3);
    send({8'hDD, 8'b01010100}, 16, 2);
    check("t2_cfg_valid", cfg_valid, 1'b1);
    check("t2_cfg", 32'(cfg()), 7'b0101010);
    // reserved bit set
    idle(3);
    send({8'hDD, 8'hFF}, 16, 1);
    check("t3_flags", {cfg_valid, frame_error, busy}, 3'b010);
    check("t3_cfg_held", 32'(cfg()), 7'b0101010);
    idle(3);
    check("t3_pulses", {cv_cnt[7:0], fe_cnt[7:0]}, 16'h0201);
    // hunt timeout clears a partial preamble silently
    send(16'b1101, 4, 1);
    idle(20001);
    send({4'b1101, 8'h00}, 12, 1);
    idle(3);
    check("th_no_frame", {cv_cnt[7:0], fe_cnt[7:0], 7'd0, busy}, 24'h020100);
    // payload timeout
    send({8'hDD, 4'b1011}, 12, 1);
    idle(20000);
    check("t4_before_timeout", {frame_error, busy}, 2'b01);
    idle(1);
    check("t4_timeout", {cfg_valid, frame_error, busy}, 3'b010);
    idle(1);
    check("t4_error_drop", frame_error, 1'b0);
    idle(5);
    check("t4_pulses", {cv_cnt[7:0], fe_cnt[7:0]}, 16'h0202);
    send(16'b1101110110110110, 16, 1);
    check("t4_recover", {cfg_valid, 25'd0, cfg()}, {1'b1, 25'd0, 7'b1011011});
    // bit arriving exactly on the timeout cycle
    idle(2);
    send({8'hDD, 4'b0110}, 12, 1);
    idle(20000);
    send(16'b0110, 4, 1);
    check("t5_commit", {cfg_valid, frame_error}, 2'b10);
    check("t5_cfg", 32'(cfg()), 7'b0110011);
    // 16 back-to-back strobes
    idle(2);
    send({8'hDD, 8'b10011000}, 16, 0);
    check("t6_commit", cfg_valid, 1'b1);
    check("t6_cfg", 32'(cfg()), 7'b1001100);
    // reset mid-frame
    idle(2);
    send({8'hDD, 4'b1110}, 12, 1);
    check("t7_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t7_async_cfg", 32'(cfg()), 32'h0);
    check("t7_async_flags", {cfg_valid, frame_error, busy}, 3'b000);
    @(negedge clock);
    reset = 1'b1;
    idle(1);
    send({8'hDD, 8'b11100100}, 16, 1);
    check("t7_commit", cfg_valid, 1'b1);
    check("t7_cfg", 32'(cfg()), 7'b1110010);
    idle(3);
    check("final_pulses", {cv_cnt[7:0], fe_cnt[7:0]}, 16'h0602);
    check("never_both", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
